// File: rtl/mash_pkg.sv
// Shared types and helpers for the MASH 1-1 sample-feed sequencer.
package mash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_PRIME     = 3'd2,
    ST_RUN       = 3'd3,
    ST_RAMP_DOWN = 3'd4
  } feed_state_e;

  // Midscale of an unsigned offset-binary code of the given width.
  function automatic logic [31:0] mid_value(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/mash_sample_fifo.sv
// Single-clock sample FIFO with occupancy count and a synchronous flush.
module mash_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         aclk,
  input  logic                         arst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Overflow and underflow are blocked here, whatever the caller requests.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/mash_feed_ctrl.sv
// Sample-feed sequencer: buffers samples, holds each for OSR modulator cycles,
// and ramps between 0 and midscale on start-up and shutdown.
// Handshake: a beat transfers on each aclk edge where tvalid && tready;
// valid never depends combinationally on ready.
module mash_feed_ctrl
  import mash_pkg::*;
#(
  parameter int              WIDTH      = 16,
  parameter int              OSR        = 64,
  parameter int              FIFO_DEPTH = 8,
  parameter logic [WIDTH-1:0] RAMP_STEP = 16'h0100
) (
  input  logic                              aclk,
  input  logic                              arst_n,
  input  logic                              enable,
  input  logic [WIDTH-1:0]                  s_axis_data_tdata,
  input  logic                              s_axis_data_tvalid,
  output logic                              s_axis_data_tready,
  output logic [WIDTH-1:0]                  m_axis_data_tdata,
  output logic                              m_axis_data_tvalid,
  input  logic                              m_axis_data_tready,
  output logic                              running,
  output logic                              underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic [2:0]                        dbg_state
);

  localparam int               PW        = $clog2(OSR);
  localparam int               LW        = $clog2(FIFO_DEPTH+1);
  localparam logic [WIDTH:0]   MID       = (WIDTH+1)'(mid_value(WIDTH));
  localparam logic [PW-1:0]    PH_LAST   = PW'(OSR-1);
  localparam logic [LW-1:0]    PRIME_LVL = LW'(FIFO_DEPTH/2);

  feed_state_e      state, state_nxt;
  logic [PW-1:0]    phase, phase_nxt;
  logic [WIDTH-1:0] value, value_nxt;
  logic             underrun_nxt;
  logic             boundary;
  logic             fifo_push, fifo_pop, fifo_flush;
  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic [WIDTH:0]   up_sum, dn_diff;
  logic [WIDTH-1:0] up_val, dn_val;

  mash_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .push      (fifo_push),
    .push_data (s_axis_data_tdata),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // One extra bit keeps the ramp saturating instead of wrapping.
  assign up_sum  = {1'b0, value} + {1'b0, RAMP_STEP};
  assign dn_diff = {1'b0, value} - {1'b0, RAMP_STEP};
  assign up_val  = (up_sum >= MID) ? MID[WIDTH-1:0] : up_sum[WIDTH-1:0];
  assign dn_val  = dn_diff[WIDTH] ? '0 : dn_diff[WIDTH-1:0];

  assign boundary  = (phase == PH_LAST) && m_axis_data_tready;
  assign fifo_push = s_axis_data_tvalid && s_axis_data_tready;

  assign s_axis_data_tready = !fifo_full &&
                              (state inside {ST_RAMP_UP, ST_PRIME, ST_RUN});
  assign m_axis_data_tvalid = (state != ST_IDLE);
  assign m_axis_data_tdata  = value;
  assign running            = (state == ST_RUN);
  assign dbg_state          = state;

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= ST_IDLE;
      phase    <= '0;
      value    <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      value    <= value_nxt;
      underrun <= underrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    value_nxt    = value;
    underrun_nxt = underrun;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;

    if (state != ST_IDLE && m_axis_data_tready)
      phase_nxt = boundary ? '0 : phase + PW'(1);

    unique case (state)
      ST_IDLE: begin
        phase_nxt = '0;
        value_nxt = '0;
        if (enable) begin
          state_nxt    = ST_RAMP_UP;
          underrun_nxt = 1'b0;
        end
      end
      ST_RAMP_UP, ST_PRIME, ST_RUN: begin
        // Dropping enable wins over any boundary action on the same edge.
        if (!enable) begin
          state_nxt = ST_RAMP_DOWN;
        end else if (boundary) begin
          if (state == ST_RAMP_UP) begin
            if ({1'b0, value} == MID) state_nxt = ST_PRIME;
            else                      value_nxt = up_val;
          end else if (state == ST_PRIME) begin
            if (fifo_level >= PRIME_LVL) begin
              state_nxt = ST_RUN;
              fifo_pop  = 1'b1;
              value_nxt = fifo_head;
            end
          end else begin
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              value_nxt = fifo_head;
            end else begin
              underrun_nxt = 1'b1;
            end
          end
        end
      end
      ST_RAMP_DOWN: begin
        if (boundary) begin
          if (value == '0) begin
            state_nxt  = ST_IDLE;
            fifo_flush = 1'b1;
          end else begin
            value_nxt = dn_val;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mash_feed_ctrl.sv
// Self-checking bench for mash_feed_ctrl with a queue-based sample model.
module tb_mash_feed_ctrl;

  localparam int          OSR   = 4;
  localparam int          DEPTH = 8;
  localparam logic [15:0] STEP  = 16'h2000;
  localparam logic [15:0] MIDV  = 16'h8000;

  logic        aclk = 1'b0;
  logic        arst_n;
  logic        enable;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        running;
  logic        underrun;
  logic [3:0]  fifo_level;
  logic [2:0]  dbg_state;

  logic [15:0] exp_q[$];
  logic [15:0] exp_data;
  logic        exp_underrun;
  int          ready_cnt;
  int          n_cmp = 0;
  int          n_fail = 0;

  mash_feed_ctrl #(
    .WIDTH(16), .OSR(OSR), .FIFO_DEPTH(DEPTH), .RAMP_STEP(STEP)
  ) dut (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .enable             (enable),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .running            (running),
    .underrun           (underrun),
    .fifo_level         (fifo_level),
    .dbg_state          (dbg_state)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [15:0] ramp_up_exp(input int c);
    int v;
    v = (c / OSR) * int'(STEP);
    if (v > int'(MIDV)) v = int'(MIDV);
    return 16'(v);
  endfunction

  function automatic logic [15:0] ramp_dn_exp(input logic [15:0] start, input int d);
    int v;
    v = int'(start) - (d / OSR) * int'(STEP);
    if (v < 0) v = 0;
    return 16'(v);
  endfunction

  // One RUN-state cycle: each sample is held for OSR ready cycles, then the
  // next queued sample replaces it, or the value holds and underrun sets.
  task automatic drive_cycle(input logic v, input logic [15:0] d, input logic r);
    logic acc;
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    acc = v && s_tready;
    if (r) begin
      if (ready_cnt == OSR-1) begin
        ready_cnt = 0;
        if (exp_q.size() > 0) exp_data = exp_q.pop_front();
        else                  exp_underrun = 1'b1;
      end else begin
        ready_cnt++;
      end
    end
    if (acc) exp_q.push_back(d);
    tick();
  endtask

  task automatic test_reset();
    arst_n = 1'b0; enable = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    #12;
    n_cmp++; if (m_tdata !== 16'h0)  begin n_fail++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
    n_cmp++; if (m_tvalid !== 1'b0)  begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
    n_cmp++; if (s_tready !== 1'b0)  begin n_fail++; $display("FAIL reset_tready got=%b exp=0", s_tready); end
    n_cmp++; if (running !== 1'b0)   begin n_fail++; $display("FAIL reset_running got=%b exp=0", running); end
    n_cmp++; if (underrun !== 1'b0)  begin n_fail++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    m_tready = 1'b1;
    @(posedge aclk); #1; arst_n = 1'b1;
    tick();
    n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL idle_hold got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_startup();
    int pushed = 0;
    enable = 1'b1; m_tready = 1'b1; s_tvalid = 1'b0;
    tick();
    for (int c = 0; c < 20; c++) begin
      n_cmp++; if (m_tdata !== ramp_up_exp(c)) begin n_fail++; $display("FAIL ramp_up c=%0d got=%h exp=%h", c, m_tdata, ramp_up_exp(c)); end
      n_cmp++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL ramp_tvalid c=%0d got=%b exp=1", c, m_tvalid); end
      n_cmp++; if (dbg_state !== 3'd1) begin n_fail++; $display("FAIL ramp_state c=%0d got=%0d exp=1", c, dbg_state); end
      n_cmp++; if (fifo_level !== 4'(pushed)) begin n_fail++; $display("FAIL ramp_level c=%0d got=%0d exp=%0d", c, fifo_level, pushed); end
      s_tvalid = (pushed < 4) && (c >= 15 || $urandom_range(0, 1) == 1);
      s_tdata  = 16'($urandom);
      if (s_tvalid && s_tready) begin exp_q.push_back(s_tdata); pushed++; end
      tick();
    end
    s_tvalid = 1'b0;
    n_cmp++; if (dbg_state !== 3'd2) begin n_fail++; $display("FAIL prime_entry got=%0d exp=2", dbg_state); end
    n_cmp++; if (fifo_level !== 4'd4) begin n_fail++; $display("FAIL prime_level got=%0d exp=4", fifo_level); end
    n_cmp++; if (m_tdata !== MIDV) begin n_fail++; $display("FAIL prime_mid got=%h exp=%h", m_tdata, MIDV); end
  endtask

  task automatic test_prime_run();
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (dbg_state !== 3'd2 || m_tdata !== MIDV) begin n_fail++; $display("FAIL prime_hold c=%0d state=%0d data=%h", c, dbg_state, m_tdata); end
      tick();
    end
    n_cmp++; if (dbg_state !== 3'd3) begin n_fail++; $display("FAIL run_entry got=%0d exp=3", dbg_state); end
    n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_flag got=%b exp=1", running); end
    n_cmp++; if (m_tdata !== exp_q[0]) begin n_fail++; $display("FAIL run_first got=%h exp=%h", m_tdata, exp_q[0]); end
    exp_data = exp_q.pop_front(); ready_cnt = 0; exp_underrun = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive_cycle(1'b0, 16'h0, 1'b1);
      n_cmp++; if (m_tdata !== exp_data) begin n_fail++; $display("FAIL run_data k=%0d got=%h exp=%h", k, m_tdata, exp_data); end
      n_cmp++; if (fifo_level !== 4'(exp_q.size())) begin n_fail++; $display("FAIL run_level k=%0d got=%0d exp=%0d", k, fifo_level, exp_q.size()); end
    end
  endtask

  task automatic test_underrun();
    logic [15:0] held;
    held = exp_data;
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b0, 16'h0, 1'b1);
      n_cmp++; if (m_tdata !== held) begin n_fail++; $display("FAIL underrun_hold k=%0d got=%h exp=%h", k, m_tdata, held); end
      n_cmp++; if (underrun !== exp_underrun) begin n_fail++; $display("FAIL underrun_flag k=%0d got=%b exp=%b", k, underrun, exp_underrun); end
      n_cmp++; if (dbg_state !== 3'd3) begin n_fail++; $display("FAIL underrun_state k=%0d got=%0d exp=3", k, dbg_state); end
    end
    n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set got=%b exp=1", underrun); end
  endtask

  task automatic test_back_pressure();
    int hit_full = 0;
    for (int k = 0; k < 160; k++) begin
      n_cmp++; if (s_tready !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL bp_tready k=%0d got=%b size=%0d", k, s_tready, exp_q.size()); end
      drive_cycle(1'b1, 16'($urandom), ($urandom_range(0, 3) != 0));
      n_cmp++; if (fifo_level !== 4'(exp_q.size())) begin n_fail++; $display("FAIL bp_level k=%0d got=%0d exp=%0d", k, fifo_level, exp_q.size()); end
      n_cmp++; if (fifo_level > 4'd8) begin n_fail++; $display("FAIL bp_overflow k=%0d got=%0d max=8", k, fifo_level); end
      n_cmp++; if (m_tdata !== exp_data) begin n_fail++; $display("FAIL bp_data k=%0d got=%h exp=%h", k, m_tdata, exp_data); end
      n_cmp++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_tvalid k=%0d got=%b exp=1", k, m_tvalid); end
      if (exp_q.size() == DEPTH) hit_full++;
    end
    n_cmp++; if (hit_full == 0) begin n_fail++; $display("FAIL bp_reached_full got=0 exp>0"); end
  endtask

  task automatic test_shutdown();
    int guard = 0;
    while ((exp_q.size() != 0 || ready_cnt != 0) && guard < 200) begin
      drive_cycle(1'b0, 16'h0, 1'b1);
      guard++;
    end
    n_cmp++; if (guard >= 200) begin n_fail++; $display("FAIL drain_timeout got=%0d limit=200", guard); end
    n_cmp++; if (m_tdata !== exp_data) begin n_fail++; $display("FAIL drain_data got=%h exp=%h", m_tdata, exp_data); end
    drive_cycle(1'b1, 16'h5000, 1'b1);
    drive_cycle(1'b1, 16'($urandom), 1'b1);
    drive_cycle(1'b1, 16'($urandom), 1'b1);
    drive_cycle(1'b0, 16'h0, 1'b1);
    n_cmp++; if (m_tdata !== 16'h5000) begin n_fail++; $display("FAIL sd_start got=%h exp=5000", m_tdata); end
    n_cmp++; if (fifo_level !== 4'd2) begin n_fail++; $display("FAIL sd_level got=%0d exp=2", fifo_level); end
    enable = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
    for (int d = 1; d < 16; d++) begin
      tick();
      n_cmp++; if (m_tdata !== ramp_dn_exp(16'h5000, d)) begin n_fail++; $display("FAIL ramp_dn d=%0d got=%h exp=%h", d, m_tdata, ramp_dn_exp(16'h5000, d)); end
      n_cmp++; if (dbg_state !== 3'd4 || m_tvalid !== 1'b1) begin n_fail++; $display("FAIL ramp_dn_state d=%0d state=%0d tvalid=%b exp=4/1", d, dbg_state, m_tvalid); end
      n_cmp++; if (s_tready !== 1'b0 || fifo_level !== 4'd2) begin n_fail++; $display("FAIL ramp_dn_fifo d=%0d tready=%b level=%0d exp=0/2", d, s_tready, fifo_level); end
      if (d == 8) enable = 1'b1;
    end
    tick();
    n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL sd_idle got=%0d exp=0", dbg_state); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL sd_tvalid got=%b exp=0", m_tvalid); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL sd_flush got=%0d exp=0", fifo_level); end
    n_cmp++; if (m_tdata !== 16'h0) begin n_fail++; $display("FAIL sd_zero got=%h exp=0", m_tdata); end
    exp_q.delete();
    tick();
    n_cmp++; if (dbg_state !== 3'd1 || m_tvalid !== 1'b1) begin n_fail++; $display("FAIL restart state=%0d tvalid=%b exp=1/1", dbg_state, m_tvalid); end
    n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear got=%b exp=0", underrun); end
  endtask

  task automatic test_reset_mid_run();
    int pushed = 0;
    int found = 0;
    int g = 0;
    for (int c = 0; c < 80; c++) begin
      if (dbg_state == 3'd3) begin found = 1; break; end
      s_tvalid = (pushed < 4) && (c >= 10 || $urandom_range(0, 1) == 1);
      s_tdata  = 16'($urandom);
      if (s_tvalid && s_tready) begin exp_q.push_back(s_tdata); pushed++; end
      tick();
    end
    s_tvalid = 1'b0;
    n_cmp++; if (found == 0) begin n_fail++; $display("FAIL rm_run_timeout state=%0d exp=3", dbg_state); end
    if (found == 0) return;
    n_cmp++; if (m_tdata !== exp_q[0]) begin n_fail++; $display("FAIL rm_first got=%h exp=%h", m_tdata, exp_q[0]); end
    exp_data = exp_q.pop_front(); ready_cnt = 0; exp_underrun = 1'b0;
    while (exp_q.size() < 5 && g < 20) begin
      drive_cycle(1'b1, 16'($urandom), 1'b1);
      g++;
    end
    n_cmp++; if (fifo_level !== 4'd5) begin n_fail++; $display("FAIL rm_level got=%0d exp=5", fifo_level); end
    #2; arst_n = 1'b0; #1;
    n_cmp++; if (m_tdata !== 16'h0 || m_tvalid !== 1'b0 || s_tready !== 1'b0) begin n_fail++; $display("FAIL rm_async_m tdata=%h tvalid=%b tready=%b exp=0", m_tdata, m_tvalid, s_tready); end
    n_cmp++; if (running !== 1'b0 || underrun !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL rm_async_status run=%b ur=%b level=%0d exp=0", running, underrun, fifo_level); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rm_async_state got=%0d exp=0", dbg_state); end
    s_tvalid = 1'b0;
    @(posedge aclk); #3;
    arst_n = 1'b1;
    tick();
    exp_q.delete();
    n_cmp++; if (dbg_state !== 3'd1 || m_tvalid !== 1'b1) begin n_fail++; $display("FAIL rm_restart state=%0d tvalid=%b exp=1/1", dbg_state, m_tvalid); end
    n_cmp++; if (fifo_level !== 4'd0 || m_tdata !== 16'h0) begin n_fail++; $display("FAIL rm_restart_clean level=%0d tdata=%h exp=0/0", fifo_level, m_tdata); end
  endtask

  initial begin
    exp_data = '0; exp_underrun = 1'b0; ready_cnt = 0;
    test_reset();
    test_startup();
    test_prime_run();
    test_underrun();
    test_back_pressure();
    test_shutdown();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
